// File: rtl/gaussian_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gaussian_frame_sequencer: frame gating, output monitor and watchdog       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gaussian_frame_sequencer #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_num_frames,
  input  logic       i_abort,
  input  logic       i_intr_clr,
  input  logic [7:0] i_src_data,
  input  logic       i_src_valid,
  output logic       o_src_ready,
  output logic [7:0] o_flt_data,
  output logic       o_flt_valid,
  input  logic       i_flt_ready,
  output logic       o_flt_rst,
  input  logic       i_res_valid,
  input  logic       i_res_ready,
  input  logic       i_res_last,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [7:0] o_frames_completed,
  output logic       o_done_intr,
  output logic [1:0] o_err
);

  localparam int          c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          c_LIN_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int          c_WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [18:0] c_EXP   = 19'(IMG_W * (IMG_H - 2));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [7:0]          r_num;
  logic [7:0]          r_frames;
  logic [c_COL_W-1:0]  r_col;
  logic [c_LIN_W-1:0]  r_line;
  logic [18:0]         r_out_cnt;
  logic [c_WD_W-1:0]   r_wd;
  logic                r_frame_done;
  logic                r_done_intr;
  logic [1:0]          r_err;

  logic        w_feed;
  logic        w_mon;
  logic        w_in_beat;
  logic        w_out_beat;
  logic        w_col_end;
  logic        w_last_in;
  logic        w_wd_fire;
  logic [18:0] w_out_cnt_nxt;
  logic [7:0]  w_frames_nxt;

  assign w_feed        = (r_state == S_FEED);
  assign w_mon         = w_feed || (r_state == S_DRAIN);
  assign w_in_beat     = w_feed && i_src_valid && i_flt_ready;
  assign w_out_beat    = w_mon && i_res_valid && i_res_ready;
  assign w_col_end     = (r_col == c_COL_W'(IMG_W - 1));
  assign w_last_in     = w_in_beat && w_col_end && (r_line == c_LIN_W'(IMG_H - 1));
  assign w_wd_fire     = w_mon && !w_in_beat && !w_out_beat &&
                         (r_wd == c_WD_W'(TIMEOUT_CYC - 1));
  assign w_out_cnt_nxt = r_out_cnt + 19'd1;
  assign w_frames_nxt  = r_frames + 8'd1;

  // Pass-through is purely combinational so FEED adds no latency.
  assign o_src_ready        = w_feed && i_flt_ready;
  assign o_flt_valid        = w_feed && i_src_valid;
  assign o_flt_data         = i_src_data;
  assign o_busy             = (r_state != S_IDLE);
  assign o_flt_rst          = (r_state == S_FLUSH) || (r_state == S_HALT);
  assign o_frame_done       = r_frame_done;
  assign o_frames_completed = r_frames;
  assign o_done_intr        = r_done_intr;
  assign o_err              = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_num        <= 8'd0;
      r_frames     <= 8'd0;
      r_col        <= '0;
      r_line       <= '0;
      r_out_cnt    <= 19'd0;
      r_wd         <= '0;
      r_frame_done <= 1'b0;
      r_done_intr  <= 1'b0;
      r_err        <= 2'b00;
    end else begin
      r_frame_done <= 1'b0;
      if (i_intr_clr)
        r_done_intr <= 1'b0;

      if (w_mon) begin
        if (w_in_beat) begin
          if (w_col_end) begin
            r_col  <= '0;
            r_line <= (r_line == c_LIN_W'(IMG_H - 1)) ? '0 : r_line + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        if (w_out_beat)
          r_out_cnt <= w_out_cnt_nxt;
        if (w_in_beat || w_out_beat)
          r_wd <= '0;
        else
          r_wd <= r_wd + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && (i_num_frames != 8'd0)) begin
            r_num     <= i_num_frames;
            r_frames  <= 8'd0;
            r_err     <= 2'b00;
            r_col     <= '0;
            r_line    <= '0;
            r_out_cnt <= 19'd0;
            r_wd      <= '0;
            r_state   <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_col     <= '0;
          r_line    <= '0;
          r_out_cnt <= 19'd0;
          r_wd      <= '0;
          r_state   <= i_abort ? S_HALT : S_FEED;
        end
        S_FEED: begin
          // A last marker before the frame is fully fed is a framing error.
          if (w_out_beat && i_res_last)
            r_err[0] <= 1'b1;
          if (i_abort) begin
            r_state <= S_HALT;
          end else if (w_wd_fire) begin
            r_err[1] <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_last_in) begin
            r_wd    <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_abort) begin
            r_state <= S_HALT;
          end else if (w_out_beat && i_res_last) begin
            if (w_out_cnt_nxt != c_EXP)
              r_err[0] <= 1'b1;
            r_frames     <= w_frames_nxt;
            r_frame_done <= 1'b1;
            if (w_frames_nxt == r_num) begin
              r_done_intr <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_FLUSH;
            end
          end else if (w_wd_fire) begin
            r_err[1] <= 1'b1;
            r_state  <= S_HALT;
          end
        end
        S_HALT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gaussian_frame_sequencer: directed bench on an 8x4 frame, timeout 64    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gaussian_frame_sequencer;

  localparam int c_W  = 8;
  localparam int c_H  = 4;
  localparam int c_TO = 64;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_num_frames;
  logic       i_abort;
  logic       i_intr_clr;
  logic [7:0] i_src_data;
  logic       i_src_valid;
  logic       o_src_ready;
  logic [7:0] o_flt_data;
  logic       o_flt_valid;
  logic       i_flt_ready;
  logic       o_flt_rst;
  logic       i_res_valid;
  logic       i_res_ready;
  logic       i_res_last;
  logic       o_busy;
  logic       o_frame_done;
  logic [7:0] o_frames_completed;
  logic       o_done_intr;
  logic [1:0] o_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  gaussian_frame_sequencer #(
    .IMG_W(c_W), .IMG_H(c_H), .TIMEOUT_CYC(c_TO)
  ) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_frames(i_num_frames),
    .i_abort(i_abort), .i_intr_clr(i_intr_clr), .i_src_data(i_src_data),
    .i_src_valid(i_src_valid), .o_src_ready(o_src_ready), .o_flt_data(o_flt_data),
    .o_flt_valid(o_flt_valid), .i_flt_ready(i_flt_ready), .o_flt_rst(o_flt_rst),
    .i_res_valid(i_res_valid), .i_res_ready(i_res_ready), .i_res_last(i_res_last),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frames_completed(o_frames_completed),
    .o_done_intr(o_done_intr), .o_err(o_err)
  );

  // flags = {busy, flt_rst, src_ready, flt_valid, frame_done, done_intr, err[1:0]}
  typedef struct {
    logic       start;
    logic [7:0] num;
    logic       abort;
    logic       sv;
    logic [7:0] sd;
    logic       fr;
    logic [7:0] exp_flags;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic st, input logic [7:0] n, input logic ab,
                              input logic sv, input logic [7:0] sd, input logic fr,
                              input logic [7:0] fl, input logic cd);
    vec_t v;
    v.start = st; v.num = n; v.abort = ab; v.sv = sv; v.sd = sd; v.fr = fr;
    v.exp_flags = fl; v.chk_data = cd; v.exp_data = sd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    i_start = 0; i_num_frames = 0; i_abort = 0; i_intr_clr = 0;
    i_src_data = 0; i_src_valid = 0; i_flt_ready = 0;
    i_res_valid = 0; i_res_ready = 0; i_res_last = 0;
  endtask

  task automatic pulse_clr();
    @(negedge i_clk); idle_inputs(); i_intr_clr = 1;
    @(negedge i_clk); idle_inputs();
    #1 check("intr_clr_drop", o_done_intr, 0);
  endtask

  // Feeds full frames, drains E result beats per frame with last at last_pos.
  task automatic run(input int nfr, input bit stall, input int last_pos, input bit clr_last,
                     output int in_b, output int rstc, output int donec,
                     output int intr_r, output int drain_rdy);
    int fb, ob;
    bit drain, prev, go, fin;
    bit a, b;
    in_b = 0; rstc = 0; donec = 0; intr_r = 0; drain_rdy = 0;
    fb = 0; ob = 0; drain = 0; go = 0; fin = 0; prev = o_done_intr;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge i_clk);
      idle_inputs();
      i_start = (cyc == 0);
      i_num_frames = nfr[7:0];
      a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      b = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_src_valid = a;
      i_src_data  = 8'($urandom);
      if (!drain) begin
        i_flt_ready = b;
      end else begin
        i_flt_ready = 1;
        i_res_valid = a;
        i_res_ready = b;
        i_res_last  = a && b && (ob + 1 == last_pos);
        i_intr_clr  = clr_last && i_res_last;
      end
      #1;
      if (o_flt_rst) rstc++;
      if (o_frame_done) donec++;
      if (o_done_intr && !prev) intr_r++;
      prev = o_done_intr;
      if (drain && o_src_ready) drain_rdy++;
      if (o_flt_valid && i_flt_ready) begin
        in_b++; fb++;
        if (fb == c_W * c_H) begin drain = 1; fb = 0; end
      end
      if (drain && i_res_valid && i_res_ready) begin
        ob++;
        if (i_res_last) begin drain = 0; ob = 0; end
      end
      if (o_busy) go = 1;
      if (go && !o_busy) begin fin = 1; break; end
    end
    check("run_completes", fin, 1);
    @(negedge i_clk); idle_inputs();
  endtask

  initial begin
    int in_b, rstc, donec, intr_r, drn, fcyc, rcyc, dcnt;
    vecs[0]  = mk(0, 0, 0, 0, 8'h00, 0, 8'b0000_0000, 0);
    vecs[1]  = mk(1, 0, 0, 0, 8'h00, 0, 8'b0000_0000, 0);
    vecs[2]  = mk(0, 0, 0, 0, 8'h00, 0, 8'b0000_0000, 0);
    vecs[3]  = mk(1, 2, 0, 1, 8'h11, 1, 8'b0000_0000, 0);
    vecs[4]  = mk(0, 0, 0, 1, 8'h22, 1, 8'b1100_0000, 0);
    vecs[5]  = mk(0, 0, 0, 1, 8'hA5, 1, 8'b1011_0000, 1);
    vecs[6]  = mk(0, 0, 0, 0, 8'h3C, 1, 8'b1010_0000, 0);
    vecs[7]  = mk(0, 0, 0, 1, 8'h77, 0, 8'b1001_0000, 1);
    vecs[8]  = mk(1, 5, 1, 0, 8'h00, 0, 8'b1000_0000, 0);
    vecs[9]  = mk(0, 0, 0, 0, 8'h00, 0, 8'b1100_0000, 0);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 0, 8'b0000_0000, 0);
    vecs[11] = mk(0, 0, 1, 0, 8'h00, 0, 8'b0000_0000, 0);
    vecs[12] = mk(0, 0, 0, 0, 8'h00, 0, 8'b0000_0000, 0);

    idle_inputs();
    i_rst = 1;
    repeat (3) @(negedge i_clk);
    i_rst = 0;

    for (int k = 0; k < 13; k++) begin
      @(negedge i_clk);
      idle_inputs();
      i_start = vecs[k].start; i_num_frames = vecs[k].num; i_abort = vecs[k].abort;
      i_src_valid = vecs[k].sv; i_src_data = vecs[k].sd; i_flt_ready = vecs[k].fr;
      #1;
      check($sformatf("vec%0d_flags", k),
            {o_busy, o_flt_rst, o_src_ready, o_flt_valid, o_frame_done, o_done_intr, o_err},
            vecs[k].exp_flags);
      check($sformatf("vec%0d_count", k), o_frames_completed, 0);
      if (vecs[k].chk_data) check($sformatf("vec%0d_data", k), o_flt_data, vecs[k].exp_data);
    end

    // One frame, continuous handshake
    run(1, 0, 16, 0, in_b, rstc, donec, intr_r, drn);
    check("one_in_beats", in_b, 32);
    check("one_flt_rst", rstc, 1);
    check("one_frame_done", donec, 1);
    check("one_count", o_frames_completed, 1);
    check("one_intr", o_done_intr, 1);
    check("one_err", o_err, 0);
    check("one_drain_ready", drn, 0);
    pulse_clr();

    // Three frames, random stalls
    run(3, 1, 16, 0, in_b, rstc, donec, intr_r, drn);
    check("three_in_beats", in_b, 96);
    check("three_flt_rst", rstc, 3);
    check("three_frame_done", donec, 3);
    check("three_count", o_frames_completed, 3);
    check("three_intr_rises", intr_r, 1);
    check("three_err", o_err, 0);
    check("three_drain_ready", drn, 0);
    pulse_clr();

    // Last marker while still feeding
    @(negedge i_clk); idle_inputs(); i_start = 1; i_num_frames = 1;
    @(negedge i_clk); idle_inputs();
    dcnt = 0;
    repeat (5) begin
      @(negedge i_clk); idle_inputs(); i_src_valid = 1; i_flt_ready = 1;
    end
    @(negedge i_clk); idle_inputs(); i_res_valid = 1; i_res_ready = 1; i_res_last = 1;
    repeat (3) begin
      @(negedge i_clk); idle_inputs();
      #1 if (o_frame_done) dcnt++;
    end
    check("feedlast_err", o_err, 2'b01);
    check("feedlast_no_done", dcnt, 0);
    check("feedlast_busy", o_busy, 1);
    @(negedge i_clk); idle_inputs(); i_abort = 1;
    @(negedge i_clk); idle_inputs();
    #1 check("abort_halt_rst", o_flt_rst, 1);
    @(negedge i_clk); idle_inputs();
    #1 check("abort_idle", {o_busy, o_done_intr, o_frames_completed}, 10'd0);

    // Short frame: last on 15th result beat
    run(1, 0, 15, 0, in_b, rstc, donec, intr_r, drn);
    check("short_err", o_err, 2'b01);
    check("short_count", o_frames_completed, 1);
    check("short_done", donec, 1);
    pulse_clr();

    // Watchdog: filter never ready
    fcyc = 0; rcyc = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge i_clk); idle_inputs();
      i_start = (cyc == 0); i_num_frames = 1; i_src_valid = 1;
      #1;
      if (o_busy && !o_flt_rst) fcyc++;
      if (o_flt_rst) rcyc++;
      if (cyc > 0 && !o_busy) break;
    end
    check("wd_feed_cycles", fcyc, c_TO);
    check("wd_rst_cycles", rcyc, 2);
    check("wd_err", o_err, 2'b10);
    check("wd_no_intr", o_done_intr, 0);
    check("wd_idle", o_busy, 0);

    // Clear coincident with final completion: set wins
    run(1, 0, 16, 1, in_b, rstc, donec, intr_r, drn);
    check("clr_race_intr", o_done_intr, 1);
    check("clr_race_count", o_frames_completed, 1);
    @(negedge i_clk);
    #1 check("clr_race_hold", o_done_intr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gaussian_frame_sequencer.md
# gaussian_frame_sequencer

Frame-level controller in front of the Gaussian filter line-buffer/window stage. It accepts a software start command with a frame count and gates the upstream 8-bit pixel stream into the filter exactly IMG_W×IMG_H beats per frame. It monitors the filter's 72-bit window output handshake, counting beats and checking the end-of-frame marker, and recovers a stalled filter with a watchdog. It also raises per-frame and end-of-run events for the interrupt controller.

## Interface
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- TIMEOUT_CYC, 1048576, idle cycles (no filter handshake) before watchdog fires
- i_clk  in  1  sole clock, all logic rising-edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle start command
- i_num_frames  in  8  frames to process, latched on accepted start
- i_abort  in  1  abort current run
- i_intr_clr  in  1  clears o_done_intr
- i_src_data  in  8  upstream pixel
- i_src_valid  in  1  upstream valid
- o_src_ready  out  1  upstream ready
- o_flt_data  out  8  pixel to filter
- o_flt_valid  out  1  valid to filter
- i_flt_ready  in  1  filter input ready
- o_flt_rst  out  1  synchronous reset to filter, one cycle
- i_res_valid, i_res_ready, i_res_last  in  1 each  filter output handshake, monitored only
- o_busy  out  1  run in progress
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_frames_completed  out  8  frames completed in current/last run
- o_done_intr  out  1  level, run finished normally
- o_err  out  2  sticky: [0] output count/last mismatch, [1] watchdog

## Operation
- States: IDLE, FLUSH, FEED, DRAIN, HALT. o_busy = (state != IDLE); o_flt_rst = (state == FLUSH || state == HALT).
- IDLE: i_start with i_num_frames != 0 → FLUSH; latch count, clear o_frames_completed, o_err, all counters. i_start with 0 ignored. i_start in non-IDLE states ignored.
- FLUSH: one cycle → FEED.
- FEED: o_flt_data = i_src_data, o_flt_valid = i_src_valid, o_src_ready = i_flt_ready (combinational). In all other states, o_flt_valid = 0 and o_src_ready = 0. Input beat = i_src_valid & i_flt_ready. Column counter wraps at IMG_W-1 into a line counter. The beat at column IMG_W-1, line IMG_H-1 → DRAIN, counters cleared.
- Output monitor (FEED and DRAIN): out beat = i_res_valid & i_res_ready; 19-bit out counter increments per beat. Expected beats per frame E = IMG_W×(IMG_H-2).
- DRAIN: an out beat with i_res_last ends the frame. If the out count including this beat != E, set o_err[0]. Increment o_frames_completed and pulse o_frame_done next cycle. If completed == latched count → IDLE and set o_done_intr; else → FLUSH.
- Out beat with i_res_last during FEED: set o_err[0], no frame completion.
- Watchdog: counter cleared on any input or out beat and on state entry; increments in FEED/DRAIN otherwise. At TIMEOUT_CYC-1 → set o_err[1], → HALT.
- i_abort in FLUSH/FEED/DRAIN → HALT, no o_done_intr. Abort has priority over frame completion and watchdog in the same cycle. HALT: one cycle → IDLE.
- o_done_intr: set/clear same cycle → set wins. Holds until i_intr_clr.
- o_frames_completed, o_err hold after the run until the next accepted start.

## Timing
- Reset: state IDLE; o_busy, o_flt_rst, o_flt_valid, o_src_ready, o_frame_done, o_done_intr = 0; o_frames_completed = 0; o_err = 0.
- Start accepted at cycle t: t+1 FLUSH (o_busy=1, o_flt_rst=1); t+2 FEED, pass-through active with zero latency.
- Final input beat at t: t+1 DRAIN, o_src_ready=0.
- Final last-beat at t: t+1 o_frame_done=1, updated count visible. Last frame: state IDLE, o_done_intr=1, o_busy=0 at t+1. Otherwise FLUSH at t+1.
- Abort at t: t+1 HALT (o_flt_rst=1), t+2 IDLE.
- Reset mid-run returns to the reset state next cycle. No o_flt_rst is issued; the filter shares i_rst.

## Test plan
- IMG_W=8, IMG_H=4, num=1, continuous valid/ready: 32 input beats, then 16 out beats with last on the 16th. Required: o_frame_done once, count=1, o_done_intr=1, o_err=0.
- num=3 with random 50% valid/ready stalls: exactly 96 input beats and o_flt_rst pulsed 3 times. Required: count=3, a single o_done_intr; i_intr_clr drops it.
- Last on the 15th out beat: o_err=2'b01, frame still counted. Last during FEED: o_err[0]=1, no o_frame_done.
- TIMEOUT_CYC=64, i_flt_ready held 0 in FEED: after 64 idle cycles o_err=2'b10, one-cycle HALT with o_flt_rst, IDLE, o_done_intr=0.
- Abort mid-FEED concurrent with i_start: HALT→IDLE, start ignored. i_start with num=0: o_busy stays 0.
- i_intr_clr in the same cycle as the final frame completes: o_done_intr=1.
